// File: rtl/mips_pkg.sv
// Shared memory-stage definitions: access-size encoding, LSU state encoding
// and small size/alignment helpers.
package mips_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;
   localparam logic [1:0] SIZE_RSVD = 2'd3;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_t;

   // The reserved size code behaves exactly like a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      logic [1:0] result;
      case (size)
         SIZE_BYTE: result = SIZE_BYTE;
         SIZE_HALF: result = SIZE_HALF;
         default:   result = SIZE_WORD;
      endcase
      return result;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic result;
      case (size)
         SIZE_BYTE: result = 1'b0;
         SIZE_HALF: result = addr_lo[0];
         default:   result = (addr_lo != 2'b00);
      endcase
      return result;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Right-justified load data extension: byte/half sign- or zero-extended,
// word passed through unchanged.
module load_extend
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            size,
   input  logic                  sign_extend,
   input  logic [DATA_WIDTH-1:0] raw,
   output logic [DATA_WIDTH-1:0] result
);

   // Replicate the access-width top bit (or zero) into the upper bits.
   always_comb begin
      result = raw;
      case (size)
         SIZE_BYTE: result = {{(DATA_WIDTH-8){sign_extend & raw[7]}}, raw[7:0]};
         SIZE_HALF: result = {{(DATA_WIDTH-16){sign_extend & raw[15]}}, raw[15:0]};
         default:   result = raw;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: IDLE/REQ/WAIT/DONE handshake with the shared
// memory port. Define LSU_UNALIGNED_TRAP_EN to trap misaligned accesses
// (addr_err) instead of silently aligning them.
module load_store_unit
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic                  req_rw,
   input  logic [1:0]            req_size,
   input  logic                  req_sign_extend,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [4:0]            req_rd,
   output logic                  stall,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic [1:0]            mem_access_size,
   output logic                  mem_rw,
   output logic                  mem_enable,
   input  logic                  mem_busy,
   output logic                  wb_valid,
   output logic [4:0]            wb_rd,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  addr_err
);

   lsu_state_t            state_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic [DATA_WIDTH-1:0] mem_din_r;
   logic [1:0]            mem_size_r;
   logic                  mem_rw_r;
   logic                  mem_enable_r;
   logic                  sign_r;
   logic [4:0]            rd_r;
   logic                  wb_valid_r;
   logic [4:0]            wb_rd_r;
   logic [DATA_WIDTH-1:0] wb_data_r;
   logic                  addr_err_r;

   logic [1:0]            size_s;
   logic [ADDR_WIDTH-1:0] addr_fix_s;
   logic [DATA_WIDTH-1:0] wdata_mask_s;
   logic [DATA_WIDTH-1:0] ext_s;
   logic                  trap_s;

`ifdef LSU_UNALIGNED_TRAP_EN
   assign trap_s = misaligned(size_s, req_addr[1:0]);
`else
   assign trap_s = 1'b0;
`endif

   // Normalise the request: clear low address bits and mask store data to width.
   always_comb begin
      size_s     = norm_size(req_size);
      addr_fix_s = req_addr;
      if (size_s == SIZE_HALF) begin
         addr_fix_s[0] = 1'b0;
      end else if (size_s == SIZE_WORD) begin
         addr_fix_s[1:0] = 2'b00;
      end else begin
         addr_fix_s = req_addr;
      end
      case (size_s)
         SIZE_BYTE: wdata_mask_s = {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]};
         SIZE_HALF: wdata_mask_s = {{(DATA_WIDTH-16){1'b0}}, req_wdata[15:0]};
         default:   wdata_mask_s = req_wdata;
      endcase
   end

   load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
      .size        (mem_size_r),
      .sign_extend (sign_r),
      .raw         (mem_dout),
      .result      (ext_s)
   );

   // Access sequencer; strobes default low so each one lasts a single cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= LSU_IDLE;
         mem_addr_r   <= '0;
         mem_din_r    <= '0;
         mem_size_r   <= 2'd0;
         mem_rw_r     <= 1'b0;
         mem_enable_r <= 1'b0;
         sign_r       <= 1'b0;
         rd_r         <= 5'd0;
         wb_valid_r   <= 1'b0;
         wb_rd_r      <= 5'd0;
         wb_data_r    <= '0;
         addr_err_r   <= 1'b0;
      end else begin
         mem_enable_r <= 1'b0;
         wb_valid_r   <= 1'b0;
         addr_err_r   <= 1'b0;
         case (state_r)
            LSU_IDLE: begin
               if (req_valid && trap_s) begin
                  addr_err_r <= 1'b1;
                  state_r    <= LSU_DONE;
               end else if (req_valid) begin
                  mem_addr_r   <= addr_fix_s;
                  mem_din_r    <= wdata_mask_s;
                  mem_size_r   <= size_s;
                  mem_rw_r     <= req_rw;
                  sign_r       <= req_sign_extend;
                  rd_r         <= req_rd;
                  mem_enable_r <= 1'b1;
                  state_r      <= LSU_REQ;
               end else begin
                  state_r <= LSU_IDLE;
               end
            end
            LSU_REQ: state_r <= LSU_WAIT;
            LSU_WAIT: begin
               if (!mem_busy) begin
                  // Write-back registers only move on a completed load.
                  if (!mem_rw_r) begin
                     wb_data_r  <= ext_s;
                     wb_rd_r    <= rd_r;
                     wb_valid_r <= (rd_r != 5'd0);
                  end
                  state_r <= LSU_DONE;
               end else begin
                  state_r <= LSU_WAIT;
               end
            end
            LSU_DONE: state_r <= LSU_IDLE;
            default:  state_r <= LSU_IDLE;
         endcase
      end
   end

   assign stall = ((state_r == LSU_IDLE) && req_valid) ||
                  (state_r == LSU_REQ) || (state_r == LSU_WAIT);

   assign mem_addr        = mem_addr_r;
   assign mem_din         = mem_din_r;
   assign mem_access_size = mem_size_r;
   assign mem_rw          = mem_rw_r;
   assign mem_enable      = mem_enable_r;
   assign wb_valid        = wb_valid_r;
   assign wb_rd           = wb_rd_r;
   assign wb_data         = wb_data_r;
   assign addr_err        = addr_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// operations against a transaction-level reference model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_rw;
   logic [1:0]  req_size;
   logic        req_sign_extend;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic [1:0]  mem_access_size;
   logic        mem_rw;
   logic        mem_enable;
   logic        mem_busy;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        addr_err;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_data;
   logic [4:0]  last_rd;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rw(req_rw),
      .req_size(req_size), .req_sign_extend(req_sign_extend), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_access_size(mem_access_size),
      .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .addr_err(addr_err)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One operation; w = number of WAIT cycles (busy low only in the last one).
   task automatic run_op(input logic rw, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic [31:0] dout, input int w);
      int          nbytes;
      logic [31:0] nb_v, mask, ex_addr, ex_din, ex_data;
      logic [1:0]  ex_size;
      logic        trap, mis, ex_wb;
      int          n_en, n_wb, n_ae, n_stall, wb_k;
      logic [31:0] got_addr, got_din, got_data;
      logic [1:0]  got_size;
      logic        got_rw;
      logic [4:0]  got_rd;

      ex_size = (size == 2'd3) ? 2'd2 : size;
      nbytes  = 1 << ex_size;
      nb_v    = 32'(nbytes);
      mask    = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      mis     = (addr & (nb_v - 32'd1)) != 32'd0;
`ifdef LSU_UNALIGNED_TRAP_EN
      trap = mis;
`else
      trap = 1'b0;
`endif
      ex_addr = addr & ~(nb_v - 32'd1);
      ex_din  = wdata & mask;
      ex_data = dout & mask;
      if (sgn && dout[8 * nbytes - 1]) ex_data = ex_data | ~mask;
      ex_wb = !rw && (rd != 5'd0) && !trap;

      n_en = 0; n_wb = 0; n_ae = 0; wb_k = -1;
      got_addr = 32'd0; got_din = 32'd0; got_data = 32'd0;
      got_size = 2'd0; got_rw = 1'b0; got_rd = 5'd0;

      req_valid = 1'b1; req_rw = rw; req_size = size; req_sign_extend = sgn;
      req_addr = addr; req_wdata = wdata; req_rd = rd;
      #1;
      check_eq("stall_accept", {63'd0, stall}, 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_rw = 1'($urandom); req_size = 2'($urandom); req_sign_extend = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
      n_stall = 1;

      for (int k = 1; k <= w + 2; k++) begin
         if (mem_enable) begin
            n_en++; got_addr = mem_addr; got_din = mem_din;
            got_size = mem_access_size; got_rw = mem_rw;
         end
         if (stall) n_stall++;
         if (wb_valid) begin
            n_wb++; wb_k = k; got_data = wb_data; got_rd = wb_rd;
         end
         if (addr_err) n_ae++;
         mem_busy = (k <= w) ? 1'b1 : 1'b0;
         mem_dout = (k == w + 1) ? dout : $urandom;
         @(posedge clk); #1;
      end
      mem_busy = 1'b0;

      check_eq("enable_count", 64'(n_en), trap ? 64'd0 : 64'd1);
      if (!trap) begin
         check_eq("mem_addr", {32'd0, got_addr}, {32'd0, ex_addr});
         check_eq("mem_size", {62'd0, got_size}, {62'd0, ex_size});
         check_eq("mem_rw", {63'd0, got_rw}, {63'd0, rw});
         if (rw) check_eq("mem_din", {32'd0, got_din}, {32'd0, ex_din});
      end
      check_eq("wb_count", 64'(n_wb), ex_wb ? 64'd1 : 64'd0);
      if (ex_wb) begin
         check_eq("wb_latency", 64'(wb_k), 64'(w + 2));
         check_eq("wb_data", {32'd0, got_data}, {32'd0, ex_data});
         check_eq("wb_rd", {59'd0, got_rd}, {59'd0, rd});
      end
      check_eq("addr_err_count", 64'(n_ae), trap ? 64'd1 : 64'd0);
      check_eq("stall_cycles", 64'(n_stall), trap ? 64'd1 : 64'(2 + w));
      if (!rw && !trap) begin
         last_data = ex_data;
         last_rd   = rd;
      end
      check_eq("wb_data_hold", {32'd0, wb_data}, {32'd0, last_data});
      check_eq("wb_rd_hold", {59'd0, wb_rd}, {59'd0, last_rd});
   endtask

   task automatic check_cleared(input string tag);
      check_eq({tag, "_stall"}, {63'd0, stall}, 64'd0);
      check_eq({tag, "_enable"}, {63'd0, mem_enable}, 64'd0);
      check_eq({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
      check_eq({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
      check_eq({tag, "_mem_din"}, {32'd0, mem_din}, 64'd0);
      check_eq({tag, "_mem_rw"}, {63'd0, mem_rw}, 64'd0);
      check_eq({tag, "_size"}, {62'd0, mem_access_size}, 64'd0);
      check_eq({tag, "_wb_data"}, {32'd0, wb_data}, 64'd0);
      check_eq({tag, "_wb_rd"}, {59'd0, wb_rd}, 64'd0);
      check_eq({tag, "_addr_err"}, {63'd0, addr_err}, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'd0;
      req_sign_extend = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
      mem_dout = 32'd0; mem_busy = 1'b0;
      last_data = 32'd0; last_rd = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 5'd5, 32'h0000_00F0, 1);
      run_op(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 5'd7, 32'h0000_8001, 4);
      run_op(1'b1, 2'd0, 1'b0, 32'h31, 32'hDEAD_BEEF, 5'd3, 32'h0, 1);
      run_op(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 5'd9, 32'h1234_5678, 2);
      run_op(1'b0, 2'd2, 1'b1, 32'h40, 32'h0, 5'd0, 32'h8000_0000, 1);
      run_op(1'b1, 2'd1, 1'b0, 32'h23, 32'hCAFE_F00D, 5'd1, 32'h0, 2);
      run_op(1'b0, 2'd3, 1'b1, 32'h81, 32'h0, 5'd31, 32'h8765_4321, 1);

      // Reset while WAIT with memory still busy.
      req_valid = 1'b1; req_rw = 1'b0; req_size = 2'd2; req_sign_extend = 1'b0;
      req_addr = 32'h100; req_wdata = 32'h0; req_rd = 5'd4;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_busy = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      check_eq("pre_reset_stall", {63'd0, stall}, 64'd1);
      rst_n = 1'b0;
      #1;
      check_cleared("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1; mem_busy = 1'b0;
      last_data = 32'd0; last_rd = 5'd0;
      run_op(1'b0, 2'd1, 1'b1, 32'h200, 32'h0, 5'd12, 32'h0000_F00F, 1);

      for (int i = 0; i < 60; i++) begin
         run_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                5'($urandom), $urandom, int'($urandom_range(1, 5)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
